// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage data-RAM access unit: handshaked bus request, load
//            formatting, pipeline stall, misalignment and bus-timeout flags.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_addr,
  input  logic [31:0] alu_result,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_request,
  output logic [31:0] result_data,
  output logic        addr_error,
  output logic        bus_error
);

  localparam int C_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);
  localparam bit C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_inc;
  logic [31:0]        r_load;
  logic               w_mem_op;
  logic               w_is_read;
  logic               w_is_store;
  logic               w_word;
  logic               w_misaligned;
  logic               w_timeout;
  logic [1:0]         w_off;
  logic [7:0]         w_byte;
  logic [31:0]        w_load_fmt;
  logic [3:0]         w_strobes;
  logic [31:0]        w_store_data;

  assign w_off        = mem_addr[1:0];
  assign w_word       = (mem_sel == 4'b1111);
  assign w_mem_op     = (mem_read_flag | mem_write_flag) & (mem_sel != 4'b0000);
  // A read with the write flag also set is still a read.
  assign w_is_read    = mem_read_flag;
  assign w_is_store   = mem_write_flag & ~mem_read_flag;
  assign w_misaligned = w_word & (w_off != 2'b00);
  assign w_cnt_inc    = r_cnt + C_ONE;
  assign w_timeout    = C_TIMEOUT_EN && (w_cnt_inc == C_LIMIT);

  always_comb begin
    w_byte = ram_read_data[7:0];
    case (w_off)
      2'd0:    w_byte = ram_read_data[7:0];
      2'd1:    w_byte = ram_read_data[15:8];
      2'd2:    w_byte = ram_read_data[23:16];
      default: w_byte = ram_read_data[31:24];
    endcase
  end

  assign w_load_fmt   = w_word ? ram_read_data
                               : {{24{mem_sign_ext_flag & w_byte[7]}}, w_byte};
  assign w_strobes    = w_is_store ? (w_word ? 4'b1111 : (4'b0001 << w_off)) : 4'b0000;
  assign w_store_data = w_word ? mem_write_data : {4{mem_write_data[7:0]}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    stall_request = 1'b0;
    result_data   = alu_result;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          stall_request = 1'b1;
          w_state_next  = w_misaligned ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall_request = 1'b1;
        if (ram_ready || w_timeout) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        result_data  = r_load;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt          <= '0;
      r_load         <= '0;
      ram_en         <= 1'b0;
      ram_write_en   <= 4'b0000;
      ram_addr       <= '0;
      ram_write_data <= '0;
      addr_error     <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_mem_op) begin
            if (w_misaligned) begin
              addr_error <= 1'b1;
              bus_error  <= 1'b0;
              r_load     <= '0;
            end else begin
              ram_en         <= 1'b1;
              ram_write_en   <= w_strobes;
              ram_addr       <= {mem_addr[31:2], 2'b00};
              ram_write_data <= w_store_data;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= w_cnt_inc;
          // Ready takes priority over a timeout landing on the same cycle.
          if (ram_ready) begin
            ram_en       <= 1'b0;
            ram_write_en <= 4'b0000;
            r_load       <= w_is_read ? w_load_fmt : '0;
            addr_error   <= 1'b0;
            bus_error    <= 1'b0;
          end else if (w_timeout) begin
            ram_en       <= 1'b0;
            ram_write_en <= 4'b0000;
            r_load       <= '0;
            addr_error   <= 1'b0;
            bus_error    <= 1'b1;
          end
        end
        ST_DONE: begin
          addr_error <= 1'b0;
          bus_error  <= 1'b0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a transaction-level
//            timing/result model and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_flag = 1'b0;
  logic        mem_write_flag = 1'b0;
  logic        mem_sign_ext_flag = 1'b0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] ram_read_data = '0;
  logic        ram_ready = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        stall_request;
  logic [31:0] result_data;
  logic        addr_error;
  logic        bus_error;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .mem_addr          (mem_addr),
    .alu_result        (alu_result),
    .ram_en            (ram_en),
    .ram_write_en      (ram_write_en),
    .ram_addr          (ram_addr),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .ram_ready         (ram_ready),
    .stall_request     (stall_request),
    .result_data       (result_data),
    .addr_error        (addr_error),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Current transaction as seen by the model.
  bit          t_active = 1'b0;
  int          t_start, t_k, t_kk;
  bit          t_mis, t_to, t_rd, t_wr, t_sx;
  logic [3:0]  t_sel;
  logic [31:0] t_wd, t_addr, t_rdata;
  logic [31:0] t_alu = '0;

  // Observations for the literal checks.
  int          tx_stall, tx_en;
  logic [31:0] last_res, last_ra, last_wd;
  logic [3:0]  last_we;
  logic        last_ae, last_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] m_result();
    int unsigned b;
    if (t_to || !t_rd) return 32'h0;
    if (t_sel == 4'hF) return t_rdata;
    b = (t_rdata >> (8 * t_addr[1:0])) & 32'hFF;
    if (t_sx && b >= 128) b = b + 32'hFFFFFF00;
    return b;
  endfunction

  function automatic logic [3:0] m_strobes();
    if (t_rd || !t_wr) return 4'h0;
    if (t_sel == 4'hF) return 4'hF;
    return 4'(1 << t_addr[1:0]);
  endfunction

  function automatic logic [31:0] m_store_data();
    if (t_sel == 4'hF) return t_wd;
    return (t_wd & 32'hFF) * 32'h01010101;
  endfunction

  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      if (!t_active) begin
        chk("idle_stall",  32'(stall_request), 32'h0);
        chk("idle_en",     32'(ram_en), 32'h0);
        chk("idle_we",     32'(ram_write_en), 32'h0);
        chk("idle_result", result_data, t_alu);
        chk("idle_aerr",   32'(addr_error), 32'h0);
        chk("idle_berr",   32'(bus_error), 32'h0);
      end else begin
        n = cyc - t_start;
        if (n == 0) begin
          chk("det_stall", 32'(stall_request), 32'h1);
          chk("det_en",    32'(ram_en), 32'h0);
        end else if (!t_mis && n <= t_kk + 1) begin
          chk("req_stall", 32'(stall_request), 32'h1);
          chk("req_en",    32'(ram_en), 32'h1);
          chk("req_addr",  ram_addr, t_addr & ~32'h3);
          chk("req_we",    32'(ram_write_en), 32'(m_strobes()));
          if (t_wr && !t_rd) chk("req_wdata", ram_write_data, m_store_data());
          last_ra = ram_addr;
          last_we = ram_write_en;
          last_wd = ram_write_data;
        end else begin
          chk("done_stall", 32'(stall_request), 32'h0);
          chk("done_en",    32'(ram_en), 32'h0);
          chk("done_aerr",  32'(addr_error), 32'(t_mis));
          chk("done_berr",  32'(bus_error), 32'(t_to));
          if (!t_mis) chk("done_result", result_data, m_result());
          last_res = result_data;
          last_ae  = addr_error;
          last_be  = bus_error;
        end
        tx_stall += int'(stall_request);
        tx_en    += int'(ram_en);
      end
    end
  end

  task automatic set_idle(input logic [31:0] alu);
    mem_read_flag = 1'b0; mem_write_flag = 1'b0; mem_sel = 4'h0;
    alu_result = alu; t_alu = alu; ram_ready = 1'b1;
  endtask

  task automatic do_idle(input logic rd, input logic [3:0] sel, input logic [31:0] alu, input int cycles);
    @(posedge clk); #1;
    set_idle(alu);
    mem_read_flag = rd; mem_sel = sel;
    repeat (cycles - 1) @(posedge clk);
    @(negedge clk); #1;
    set_idle(alu);
  endtask

  // k = cycles of ram_ready low in REQ before it rises; k >= TO never completes.
  task automatic do_op(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                       input logic [31:0] wd, input logic [31:0] addr, input logic [31:0] rdata,
                       input logic [31:0] alu, input int k);
    int last_n;
    @(posedge clk); #1;
    mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sx; mem_sel = sel;
    mem_write_data = wd; mem_addr = addr; ram_read_data = rdata; alu_result = alu;
    t_rd = rd; t_wr = wr; t_sx = sx; t_sel = sel; t_wd = wd; t_addr = addr;
    t_rdata = rdata; t_alu = alu; t_k = k;
    t_mis = (sel == 4'hF) && (addr[1:0] != 2'b00);
    t_to  = !t_mis && (k >= TO);
    t_kk  = t_to ? TO - 1 : k;
    last_n = t_mis ? 1 : t_kk + 2;
    tx_stall = 0; tx_en = 0;
    t_start = cyc; t_active = 1'b1;
    for (int n = 0; n <= last_n; n++) begin
      ram_ready = (!t_mis && n >= 1 && n <= t_kk + 1) ? (n == k + 1) : 1'b1;
      if (n < last_n) begin @(posedge clk); #1; end
    end
    @(negedge clk); #1;
    t_active = 1'b0;
    set_idle(alu);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    #3 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_en",    32'(ram_en), 32'h0);
    chk("rst_we",    32'(ram_write_en), 32'h0);
    chk("rst_addr",  ram_addr, 32'h0);
    chk("rst_wdata", ram_write_data, 32'h0);
    chk("rst_aerr",  32'(addr_error), 32'h0);
    chk("rst_berr",  32'(bus_error), 32'h0);
    chk("rst_stall", 32'(stall_request), 32'h0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;

    do_idle(1'b0, 4'h0, 32'h12345678, 3);
    do_idle(1'b1, 4'h0, 32'hCAFE0001, 2);

    do_op(1, 0, 1, 4'hF, 32'h0, 32'h100, 32'h8899AABB, 32'h1, 3);
    chk("lw_result",  last_res, 32'h8899AABB);
    chk("lw_stall_n", 32'(tx_stall), 32'd5);
    chk("lw_en_n",    32'(tx_en), 32'd4);
    chk("lw_errs",    {30'h0, last_ae, last_be}, 32'h0);

    do_op(1, 0, 1, 4'h1, 32'h0, 32'h203, 32'h80112233, 32'h2, 0);
    chk("lb_result", last_res, 32'hFFFFFF80);
    chk("lb_addr",   last_ra, 32'h200);
    do_op(1, 0, 0, 4'h1, 32'h0, 32'h203, 32'h80112233, 32'h3, 1);
    chk("lbu_result", last_res, 32'h00000080);

    do_op(0, 1, 0, 4'h1, 32'h000000A5, 32'h301, 32'h0, 32'h4, 2);
    chk("sb_we",     32'(last_we), 32'h2);
    chk("sb_wdata",  last_wd, 32'hA5A5A5A5);
    chk("sb_result", last_res, 32'h0);
    do_op(0, 1, 0, 4'hF, 32'h11223344, 32'h300, 32'h0, 32'h5, 0);
    chk("sw_we",    32'(last_we), 32'hF);
    chk("sw_wdata", last_wd, 32'h11223344);

    do_op(0, 1, 0, 4'hF, 32'h55667788, 32'h402, 32'h0, 32'h6, 0);
    chk("mis_stall_n", 32'(tx_stall), 32'd1);
    chk("mis_en_n",    32'(tx_en), 32'd0);
    chk("mis_aerr",    32'(last_ae), 32'h1);

    do_op(1, 1, 0, 4'h1, 32'hFFFFFFFF, 32'h102, 32'h00F10000, 32'h7, 1);
    chk("rw_result", last_res, 32'h000000F1);
    chk("rw_we",     32'(last_we), 32'h0);

    do_op(1, 0, 0, 4'hF, 32'h0, 32'h500, 32'h12121212, 32'h8, 99);
    chk("to_berr",    32'(last_be), 32'h1);
    chk("to_result",  last_res, 32'h0);
    chk("to_stall_n", 32'(tx_stall), 32'd5);
    do_idle(1'b0, 4'h0, 32'h0BADF00D, 2);

    // Reset pulse while a load is waiting on the bus.
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = 4'hF; mem_addr = 32'h700; ram_ready = 1'b0;
    t_rd = 1; t_wr = 0; t_sx = 0; t_sel = 4'hF; t_addr = 32'h700; t_wd = 32'h0;
    t_rdata = ram_read_data; t_mis = 0; t_to = 1; t_k = 99; t_kk = TO - 1;
    t_start = cyc; t_active = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("prerst_en", 32'(ram_en), 32'h1);
    t_active = 1'b0;
    set_idle(32'h0BADF00D);
    rst = 1'b0;
    #1;
    chk("midrst_en",    32'(ram_en), 32'h0);
    chk("midrst_addr",  ram_addr, 32'h0);
    chk("midrst_stall", 32'(stall_request), 32'h0);
    chk("midrst_berr",  32'(bus_error), 32'h0);
    @(posedge clk); #2 rst = 1'b1;

    do_op(1, 0, 0, 4'hF, 32'h0, 32'h600, 32'hDEADBEEF, 32'h9, 0);
    chk("post_result",  last_res, 32'hDEADBEEF);
    chk("post_stall_n", 32'(tx_stall), 32'd2);

    do_idle(1'b0, 4'h0, 32'h00000042, 2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the MIPS32 core. It consumes the memory control set produced in decode (read/write/sign-extend flags, byte-lane select, store data) together with the EX-stage address, and drives a handshaked data-RAM port. It formats load results (byte extraction, sign/zero extension) for write-back and raises a pipeline stall while an access is outstanding. It flags misaligned word accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255, max REQ cycles waiting for `ram_ready` before bus error; 0 disables timeout
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_read_flag  in  1  LB/LBU/LW in MEM
- mem_write_flag  in  1  SB/SW in MEM
- mem_sign_ext_flag  in  1  sign-extend load result (LB, LW)
- mem_sel  in  4  0001 byte access, 1111 word access, 0000 none
- mem_write_data  in  32  store data (rs2 value)
- mem_addr  in  32  effective address from EX
- alu_result  in  32  non-memory result, passed through
- ram_en  out  1  bus request, registered
- ram_write_en  out  4  byte write strobes, registered; 0000 on reads
- ram_addr  out  32  word-aligned address {mem_addr[31:2],2'b00}, registered
- ram_write_data  out  32  lane-aligned store data, registered
- ram_read_data  in  32  read data, valid when `ram_ready`=1
- ram_ready  in  1  access complete, sampled in REQ only
- stall_request  out  1  hold IF–MEM pipeline registers
- result_data  out  32  write-back value
- addr_error  out  1  misaligned LW/SW, valid in DONE
- bus_error  out  1  timeout, valid in DONE

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, no memory op (both flags 0 or mem_sel=0000): `result_data`=`alu_result` (combinational), stall 0, stays IDLE.
- IDLE, memory op: `stall_request`=1 combinationally.
  - Word op with mem_addr[1:0]≠00 goes to DONE with addr_error set. No bus access.
  - Otherwise goes to REQ and registers ram_en=1, ram_addr, strobes and data.
- Both flags set: treated as a read; write ignored.
- Store lanes, little-endian, with o = mem_addr[1:0]:
  - SB: strobes = 0001<<o, data = {4{mem_write_data[7:0]}}.
  - SW: 1111, data unchanged.
- REQ: stall 1. Timeout counter increments every cycle.
  - On ram_ready=1: capture formatted load data, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES without ready: go to DONE with bus_error=1, result 0.
  - ram_en/strobes clear on leaving REQ.
- Load formatting:
  - LB/LBU: byte = ram_read_data[8o+7:8o]. Sign-extend if mem_sign_ext_flag, else zero-extend.
  - LW: full word.
  - Stores yield result 0.
- DONE (exactly 1 cycle): stall 0.
  - `result_data` = registered load result.
  - addr_error/bus_error reflect this access.
  - Pipeline advances at end of DONE; always returns to IDLE, so the held op is never reissued.
- Inputs must stay stable from IDLE detection through DONE (guaranteed by stall). Block does not re-sample them after IDLE.

## Timing
- Reset (rst=0, async): state IDLE, counter 0. ram_en 0, ram_write_en 0000, ram_addr 0, ram_write_data 0, addr_error 0, bus_error 0, internal load register 0. stall_request 0 and result_data=alu_result follow IDLE rules.
- Aligned op detected at cycle T.
  - ram_en high from T+1.
  - ram_ready first high at T+1+k (k≥0) gives DONE at T+2+k.
  - Total stall cycles = k+2; zero-wait RAM costs 2 stall cycles.
- Misaligned op: stall at T only, DONE at T+1, ram_en never asserts.
- Timeout: DONE at T+1+TIMEOUT_CYCLES when ready is never seen.
- ram_ready in IDLE/DONE is ignored.
- ram_ready on the same cycle the counter hits the limit: ready wins, no bus_error.
- Back-to-back memory ops: second detected in the cycle after DONE. No overlap.
- Reset asserted mid-REQ: ram_en drops immediately (async). No completion reported.

## Test plan
- LW addr 0x100, RAM ready after 3 cycles returning 0x8899AABB:
  - ram_en for 4 cycles, stall 5 cycles.
  - DONE result 0x8899AABB, errors 0.
- LB addr 0x203, data 0x80112233, sign_ext=1:
  - ram_addr 0x200, result 0xFFFFFF80.
  - Same as LBU: 0x00000080.
- SB addr 0x301, data 0x000000A5:
  - ram_write_en 0010, ram_write_data 0xA5A5A5A5, result 0.
  - SW 0x300: strobes 1111.
- SW addr 0x402: stall 1 cycle, addr_error=1 in DONE, ram_en never 1.
- TIMEOUT_CYCLES=4, ready held 0: bus_error=1 in DONE at T+5, result 0, then IDLE. Also cover ready on the limit cycle giving no error.
- rst pulsed low during REQ: all outputs return to reset values same cycle. Next LW completes normally.
